// File: rtl/sky130_sram_tiny_arb.sv
// Two-requester arbiter/sequencer for a single 1RW sky130 SRAM macro, one operation in flight.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (A wins ties); the default is round-robin.
module sky130_sram_tiny_arb #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid_a,
  output logic                  req_ready_a,
  input  logic                  req_we_a,
  input  logic [NUM_WMASKS-1:0] req_wmask_a,
  input  logic [ADDR_WIDTH-1:0] req_addr_a,
  input  logic [DATA_WIDTH-1:0] req_wdata_a,
  output logic                  rsp_valid_a,
  output logic [DATA_WIDTH-1:0] rsp_rdata_a,
  input  logic                  req_valid_b,
  output logic                  req_ready_b,
  input  logic                  req_we_b,
  input  logic [NUM_WMASKS-1:0] req_wmask_b,
  input  logic [ADDR_WIDTH-1:0] req_addr_b,
  input  logic [DATA_WIDTH-1:0] req_wdata_b,
  output logic                  rsp_valid_b,
  output logic [DATA_WIDTH-1:0] rsp_rdata_b,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CMD, RD_WAIT, RSP} state_t;

  state_t state, state_next;
  logic owner;
  logic op_we;
  logic grant_a, grant_b, accept;
  logic sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign grant_a = req_valid_a;
  assign grant_b = req_valid_b & ~req_valid_a;
`else
  // rr_last = 1 means B was granted last, so A wins the next tie.
  logic rr_last;

  assign grant_a = req_valid_a & (~req_valid_b | rr_last);
  assign grant_b = req_valid_b & (~req_valid_a | ~rr_last);

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= grant_b;
    end
  end
`endif

  assign accept = (state == IDLE) & (grant_a | grant_b);

  assign sel_we    = grant_b ? req_we_b    : req_we_a;
  assign sel_wmask = grant_b ? req_wmask_b : req_wmask_a;
  assign sel_addr  = grant_b ? req_addr_b  : req_addr_a;
  assign sel_wdata = grant_b ? req_wdata_b : req_wdata_a;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    req_ready_a = 1'b0;
    req_ready_b = 1'b0;
    rsp_valid_a = 1'b0;
    rsp_valid_b = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        req_ready_a = grant_a;
        req_ready_b = grant_b;
        if (accept) state_next = CMD;
      end
      CMD:     state_next = op_we ? RSP : RD_WAIT;
      RD_WAIT: state_next = RSP;
      RSP: begin
        rsp_valid_a = ~owner;
        rsp_valid_b = owner;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Macro pins are registered; the strobe is low for exactly the CMD cycle, address/data hold afterwards.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      owner       <= 1'b0;
      op_we       <= 1'b0;
    end else begin
      if (accept) begin
        owner       <= grant_b;
        op_we       <= sel_we;
        sram_csb0   <= 1'b0;
        sram_web0   <= ~sel_we;
        sram_wmask0 <= sel_wmask;
        sram_addr0  <= sel_addr;
        sram_din0   <= sel_wdata;
      end else if (state == CMD) begin
        sram_csb0 <= 1'b1;
        sram_web0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      rsp_rdata_a <= '0;
      rsp_rdata_b <= '0;
    end else if (state == RD_WAIT) begin
      if (owner) rsp_rdata_b <= sram_dout0;
      else       rsp_rdata_a <= sram_dout0;
    end
  end

endmodule

// File: tb/tb_sky130_sram_tiny_arb.sv
// Directed bench for sky130_sram_tiny_arb with a behavioural 16x32 byte-masked SRAM model.
module tb_sky130_sram_tiny_arb;

  logic        clk0 = 1'b0;
  logic        rst0 = 1'b1;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        req_ready_a, req_ready_b;
  logic        req_we_a = 1'b0, req_we_b = 1'b0;
  logic [3:0]  req_wmask_a = '0, req_wmask_b = '0;
  logic [3:0]  req_addr_a = '0, req_addr_b = '0;
  logic [31:0] req_wdata_a = '0, req_wdata_b = '0;
  logic        rsp_valid_a, rsp_valid_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0, sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mem [16];
  logic [3:0]  rd_addr = '0;

  always #5 clk0 = ~clk0;

  sky130_sram_tiny_arb dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a),
    .req_wmask_a(req_wmask_a), .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a),
    .rsp_valid_a(rsp_valid_a), .rsp_rdata_a(rsp_rdata_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b),
    .req_wmask_b(req_wmask_b), .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b),
    .rsp_valid_b(rsp_valid_b), .rsp_rdata_b(rsp_rdata_b),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .busy(busy)
  );

  // Macro model: samples pins on the rising edge, read data appears after the falling edge.
  always @(posedge clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int i = 0; i < 4; i++)
          if (sram_wmask0[i]) mem[sram_addr0][8*i +: 8] <= sram_din0[8*i +: 8];
      end else begin
        rd_addr <= sram_addr0;
      end
    end
  end

  always @(negedge clk0) sram_dout0 <= mem[rd_addr];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, actual, expected);
    end
  endtask

  // One full transaction from one requester; other requester idle.
  task automatic applyStimulus(input bit use_b, input bit we, input logic [3:0] wmask,
                               input logic [3:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input int exp_lat);
    int n;
    bit other_pulsed;
    if (use_b) begin
      req_valid_b = 1'b1; req_we_b = we; req_wmask_b = wmask; req_addr_b = addr; req_wdata_b = wdata;
    end else begin
      req_valid_a = 1'b1; req_we_a = we; req_wmask_a = wmask; req_addr_a = addr; req_wdata_a = wdata;
    end
    #1;
    n = 0;
    while (!(use_b ? req_ready_b : req_ready_a) && n < 20) begin
      @(posedge clk0); #2;
      n++;
    end
    checkOutput("accept_in_time", 32'(n < 20), 32'd1);
    @(posedge clk0); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    checkOutput("cmd_csb", 32'(sram_csb0), 32'd0);
    checkOutput("cmd_web", 32'(sram_web0), 32'(!we));
    checkOutput("cmd_addr", 32'(sram_addr0), 32'(addr));
    n = 1;
    other_pulsed = 1'b0;
    while (!(use_b ? rsp_valid_b : rsp_valid_a) && n < 10) begin
      other_pulsed |= (use_b ? rsp_valid_a : rsp_valid_b);
      @(posedge clk0); #1;
      n++;
    end
    other_pulsed |= (use_b ? rsp_valid_a : rsp_valid_b);
    checkOutput("rsp_latency", 32'(n), 32'(exp_lat));
    checkOutput("rsp_other_quiet", 32'(other_pulsed), 32'd0);
    checkOutput("rsp_rdata", use_b ? rsp_rdata_b : rsp_rdata_a, exp_rdata);
    @(posedge clk0); #1;
    checkOutput("back_to_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit a_pulsed;
    logic [1:0] exp_grant [3];
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset values
    repeat (2) @(posedge clk0);
    #1;
    checkOutput("rst_csb", 32'(sram_csb0), 32'd1);
    checkOutput("rst_web", 32'(sram_web0), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_addr", 32'(sram_addr0), 32'd0);
    checkOutput("rst_rsp_a", 32'(rsp_valid_a), 32'd0);
    checkOutput("rst_rdata_a", rsp_rdata_a, 32'd0);
    rst0 = 1'b0;
    @(posedge clk0); #1;

    // Reset asserted in the CMD cycle of an A read
    req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 4'd2;
    #1;
    checkOutput("mid_ready_a", 32'(req_ready_a), 32'd1);
    @(posedge clk0); #1;
    req_valid_a = 1'b0;
    checkOutput("mid_cmd_csb", 32'(sram_csb0), 32'd0);
    rst0 = 1'b1;
    #1;
    checkOutput("mid_rst_csb", 32'(sram_csb0), 32'd1);
    checkOutput("mid_rst_web", 32'(sram_web0), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    a_pulsed = 1'b0;
    repeat (2) begin
      @(posedge clk0); #1;
      a_pulsed |= rsp_valid_a | rsp_valid_b;
    end
    rst0 = 1'b0;
    repeat (3) begin
      @(posedge clk0); #1;
      a_pulsed |= rsp_valid_a | rsp_valid_b;
    end
    checkOutput("mid_rst_no_rsp", 32'(a_pulsed), 32'd0);

    applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'h0, 3);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 32'h0, 2);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd3, 32'h0, 32'hDEADBEEF, 3);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd5, 32'h11223344, 32'hDEADBEEF, 2);
    applyStimulus(1'b0, 1'b1, 4'b0101, 4'd5, 32'hAABBCCDD, 32'hDEADBEEF, 2);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd5, 32'h0, 32'h11BB33DD, 3);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd7, 32'h0000CAFE, 32'h11BB33DD, 2);
    applyStimulus(1'b0, 1'b1, 4'h0, 4'd7, 32'hFFFFFFFF, 32'h11BB33DD, 2);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd7, 32'h0, 32'h0000CAFE, 3);
    applyStimulus(1'b1, 1'b1, 4'hF, 4'd15, 32'hB0B0F00D, 32'h0, 2);

    // B read held valid while an A write is in flight
    req_valid_a = 1'b1; req_we_a = 1'b1; req_wmask_a = 4'hF; req_addr_a = 4'd9; req_wdata_a = 32'h12345678;
    #1;
    checkOutput("b2b_ready_a", 32'(req_ready_a), 32'd1);
    @(posedge clk0); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 4'd15;
    #1;
    checkOutput("b2b_cmd_ready_b", 32'(req_ready_b), 32'd0);
    @(posedge clk0); #1;
    checkOutput("b2b_rsp_a", 32'(rsp_valid_a), 32'd1);
    checkOutput("b2b_rsp_ready_b", 32'(req_ready_b), 32'd0);
    @(posedge clk0); #1;
    checkOutput("b2b_idle_ready_b", 32'(req_ready_b), 32'd1);
    @(posedge clk0); #1;
    req_valid_b = 1'b0;
    n = 1;
    a_pulsed = 1'b0;
    while (!rsp_valid_b && n < 10) begin
      a_pulsed |= rsp_valid_a;
      @(posedge clk0); #1;
      n++;
    end
    a_pulsed |= rsp_valid_a;
    checkOutput("b2b_b_latency", 32'(n), 32'd3);
    checkOutput("b2b_a_quiet", 32'(a_pulsed), 32'd0);
    checkOutput("b2b_rdata_b", rsp_rdata_b, 32'hB0B0F00D);
    checkOutput("b2b_rdata_a_held", rsp_rdata_a, 32'h0000CAFE);
    @(posedge clk0); #1;

    // Tie arbitration straight after reset
    rst0 = 1'b1;
    @(posedge clk0); #1;
    rst0 = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01;
`else
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
`endif
    req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 4'd3;
    req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 4'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      n = 0;
      while (!(req_ready_a || req_ready_b) && n < 20) begin
        @(posedge clk0); #2;
        n++;
      end
      checkOutput("tie_grant", 32'({req_ready_b, req_ready_a}), 32'(exp_grant[k]));
      @(posedge clk0); #1;
    end
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk0); #1;
      n++;
    end
    checkOutput("tie_drain", 32'(busy), 32'd0);

    repeat (2) @(posedge clk0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
